// File: rtl/robot_pkg.sv
// Shared definitions for the robot-base command path.
//   drive_states : drive FSM output encoding (shared with the mode/drive FSM)
//   OP_*         : robot-base serial opcodes
//   tx_state_e   : state encoding of the drive_cmd_tx packet FSM
//   norm_drive() : maps unused drive codes (6, 7) onto STOP
package robot_pkg;

   typedef enum logic [2:0] {
      STOP   = 3'd0,
      LEFT   = 3'd1,
      RIGHT  = 3'd2,
      SLOW   = 3'd3,
      MEDIUM = 3'd4,
      FAST   = 3'd5
   } drive_states;

   localparam logic [7:0] OP_START        = 8'h80;
   localparam logic [7:0] OP_SAFE         = 8'h83;
   localparam logic [7:0] OP_DRIVE_DIRECT = 8'h91;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      LOAD = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } tx_state_e;

   // Codes 6 and 7 are not driven by the drive FSM; treat them as STOP so a
   // stray code never moves the base and never differs from a sent STOP.
   function automatic drive_states norm_drive(input logic [2:0] code);
      if (code > 3'd5)
         return STOP;
      return drive_states'(code);
   endfunction

endpackage

// File: rtl/drive_cmd_tx_if.sv
// Bundle between the drive FSM side and drive_cmd_tx.
//   drive_state : 3-bit drive code from the drive FSM
//   uart_tx     : serial line to the robot base RX pin (idles high)
//   tx_busy     : high while a packet or the init sequence is on the line
//   packet_done : one-cycle pulse after the last stop bit of a drive packet
// modport master : the drive FSM / observer side
// modport slave  : drive_cmd_tx
interface drive_cmd_tx_if;

   logic [2:0] drive_state;
   logic       uart_tx;
   logic       tx_busy;
   logic       packet_done;

   modport master (
      output drive_state,
      input  uart_tx,
      input  tx_busy,
      input  packet_done
   );

   modport slave (
      input  drive_state,
      output uart_tx,
      output tx_busy,
      output packet_done
   );

endinterface

// File: rtl/drive_cmd_tx_uart.sv
// 8N1 UART byte serialiser.
//   clk_50     : system clock
//   reset      : synchronous active-high reset; line returns high at once
//   byte_valid : byte_data is offered
//   byte_data  : byte to send, LSB first
//   byte_ready : serialiser is idle; a byte is taken when valid && ready
//   tx         : serial output, idles high
// Parameter CLKS_PER_BIT: bit period in clk_50 cycles (>= 2).
//
// The final cycle of the stop bit is spent idle (tx already high) so that a
// byte offered back-to-back starts exactly one byte period after the previous
// start: consecutive bytes have no gap and a byte costs 10 * CLKS_PER_BIT.
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       tx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(CLKS_PER_BIT - 2);

   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]       shift;

   assign byte_ready = ~busy;

   always_ff @(posedge clk_50) begin
      if (reset) begin
         busy    <= 1'b0;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else if (!busy) begin
         if (byte_valid) begin
            busy    <= 1'b1;
            cnt     <= CNT_FULL;
            bit_idx <= '0;
            shift   <= byte_data;
            tx      <= 1'b0;
         end
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end else if (bit_idx == 4'd9) begin
         busy <= 1'b0;
      end else begin
         bit_idx <= bit_idx + 4'd1;
         if (bit_idx == 4'd8) begin
            tx  <= 1'b1;
            cnt <= CNT_STOP;
         end else begin
            tx    <= shift[0];
            shift <= shift >> 1;
            cnt   <= CNT_FULL;
         end
      end
   end

endmodule

// File: rtl/drive_cmd_tx.sv
// Drive Direct command transmitter for the robot base.
// Turns the drive FSM's 3-bit drive state into 5-byte Drive Direct packets
// (0x91, R_hi, R_lo, L_hi, L_lo) on a UART. A packet is sent after reset and
// whenever the registered drive state differs from the last one sent; only
// the latest value is sent, and a change that reverts before LOAD sends
// nothing.
//   clk_50 : system clock
//   reset  : synchronous active-high reset; abandons any frame in flight
//   bus    : drive_cmd_tx_if.slave (drive_state in; uart_tx, tx_busy,
//            packet_done out)
// Build option DRIVE_TX_INIT_EN: when defined, every reset release first
// sends Start (0x80) and Safe (0x83) from an INIT state, with tx_busy high and
// no packet_done pulse, before the first drive packet.
//
// state | meaning
// IDLE  | nothing on the line; wait for init request or a pending packet
// INIT  | sending Start then Safe (DRIVE_TX_INIT_EN only)
// LOAD  | snapshot drive state, build packet, hand opcode to serialiser
// SEND  | hand velocity bytes 1..4 to serialiser, wait for last stop bit
// DONE  | one-cycle packet_done pulse
module drive_cmd_tx
   import robot_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int TURN_MM_S   = 100,
   parameter int SLOW_MM_S   = 100,
   parameter int MEDIUM_MM_S = 200,
   parameter int FAST_MM_S   = 300
) (
   input  logic            clk_50,
   input  logic            reset,
   drive_cmd_tx_if.slave   bus
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   localparam logic [15:0] TURN_POS = 16'(TURN_MM_S);
   localparam logic [15:0] TURN_NEG = 16'(-TURN_MM_S);
   localparam logic [15:0] SLOW_V   = 16'(SLOW_MM_S);
   localparam logic [15:0] MEDIUM_V = 16'(MEDIUM_MM_S);
   localparam logic [15:0] FAST_V   = 16'(FAST_MM_S);

   tx_state_e   state, state_n;
   drive_states ds_q;
   drive_states last_sent;
   logic        pending_q;
   logic        pending;
   logic [2:0]  idx, idx_n;
   logic [31:0] pkt_body;
   logic [15:0] vel_r, vel_l;
   logic        load_take;
   logic        init_req;

   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        tx_line;

`ifdef DRIVE_TX_INIT_EN
   logic init_q;

   always_ff @(posedge clk_50) begin
      if (reset)
         init_q <= 1'b1;
      else if (state == INIT && state_n == LOAD)
         init_q <= 1'b0;
   end

   assign init_req = init_q;
`else
   assign init_req = 1'b0;
`endif

   // A drive-state difference counts as pending combinationally, so IDLE can
   // reach LOAD the cycle after ds_q changes.
   assign pending = pending_q | (ds_q != last_sent);

   always_comb begin
      vel_r = '0;
      vel_l = '0;
      case (ds_q)
         LEFT: begin
            vel_r = TURN_POS;
            vel_l = TURN_NEG;
         end
         RIGHT: begin
            vel_r = TURN_NEG;
            vel_l = TURN_POS;
         end
         SLOW: begin
            vel_r = SLOW_V;
            vel_l = SLOW_V;
         end
         MEDIUM: begin
            vel_r = MEDIUM_V;
            vel_l = MEDIUM_V;
         end
         FAST: begin
            vel_r = FAST_V;
            vel_l = FAST_V;
         end
         default: begin
            vel_r = '0;
            vel_l = '0;
         end
      endcase
   end

   always_ff @(posedge clk_50) begin
      ds_q <= norm_drive(bus.drive_state);
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         last_sent <= STOP;
         pending_q <= 1'b1;
         pkt_body  <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         if (load_take) begin
            last_sent <= ds_q;
            pending_q <= 1'b0;
            pkt_body  <= {vel_r, vel_l};
         end
      end
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      byte_valid = 1'b0;
      byte_data  = OP_DRIVE_DIRECT;
      load_take  = 1'b0;
      case (state)
         IDLE: begin
            if (init_req) begin
               state_n = INIT;
               idx_n   = '0;
            end else if (pending) begin
               state_n = LOAD;
            end
         end
         INIT: begin
            byte_valid = (idx < 3'd2);
            byte_data  = (idx == 3'd0) ? OP_START : OP_SAFE;
            if (byte_valid && byte_ready)
               idx_n = idx + 3'd1;
            else if (idx == 3'd2 && byte_ready)
               state_n = LOAD;
         end
         LOAD: begin
            // Opcode does not depend on the snapshot, so it goes out now.
            byte_valid = 1'b1;
            byte_data  = OP_DRIVE_DIRECT;
            if (byte_ready) begin
               load_take = 1'b1;
               idx_n     = 3'd1;
               state_n   = SEND;
            end
         end
         SEND: begin
            byte_valid = (idx < 3'd5);
            case (idx)
               3'd1:    byte_data = pkt_body[31:24];
               3'd2:    byte_data = pkt_body[23:16];
               3'd3:    byte_data = pkt_body[15:8];
               default: byte_data = pkt_body[7:0];
            endcase
            if (byte_valid && byte_ready)
               idx_n = idx + 3'd1;
            else if (idx == 3'd5 && byte_ready)
               state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clk_50     (clk_50),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .tx         (tx_line)
   );

   assign bus.uart_tx     = tx_line;
   assign bus.tx_busy     = (state == INIT) || (state == LOAD) || (state == SEND);
   assign bus.packet_done = (state == DONE);

endmodule
